handshake_arbiter_rr: RTL
=========================

Name: handshake_arbiter_rr

Overview:
- Registered N-to-1 arbitrated merge for elastic dataflow channels.
- Lets several producers share one downstream resource (a constant unit, functional unit or memory port).
- Selects one valid requester per cycle and latches its data and index into a single output slot.
- Forwards the slot downstream with valid/ready handshake.
- Fairness: round-robin when compiled in, fixed priority otherwise.

Parameters:
- NUM_INPUTS, 4, number of requester channels (>=2).
- DATA_WIDTH, 32, width of each data payload.
- INDEX_WIDTH, 2, width of the winner index; must satisfy 2**INDEX_WIDTH >= NUM_INPUTS.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- ins  input  NUM_INPUTS*DATA_WIDTH  packed payloads; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ins_valid  input  NUM_INPUTS  per-channel valid.
- ins_ready  output  NUM_INPUTS  per-channel ready; at most one bit high per cycle.
- outs  output  DATA_WIDTH  registered payload of the granted channel.
- index  output  INDEX_WIDTH  registered number of the granted channel.
- outs_valid  output  1  output slot full.
- outs_ready  input  1  downstream accept.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: outs_valid=0, outs=0, index=0, rr pointer=0, ins_ready=0.
- Slot load condition: can_load = !outs_valid | outs_ready. Draining and refilling in the same cycle is allowed, so full throughput is one token per cycle.
- Grant:
  - Computed combinationally from ins_valid and the rr pointer.
  - Pick the first valid channel scanning from the pointer upward, wrapping from NUM_INPUTS-1 to 0.
  - grant is one-hot or zero.
- Ready: ins_ready[i] = grant[i] & can_load. Ready depends on ins_valid; this is accepted practice in this handshake library.
- Transfer: when any grant is set and can_load is high, on the next edge:
  - outs <= ins[g]
  - index <= g
  - outs_valid <= 1
  - pointer <= (g+1) mod NUM_INPUTS
- Drain: if outs_valid & outs_ready and no transfer occurs, outs_valid <= 0. outs and index hold their old values (don't-care).
- Stall: outs_valid & !outs_ready gives all ins_ready=0. The slot holds and outs/index stay stable while valid.
- No request: pointer unchanged; slot behaves per the drain/stall rules.
- Latency: one cycle from input handshake to outs_valid.
- Simultaneous requests: exactly one is served per cycle. A losing channel must keep valid and data stable (elastic protocol) and is served later.
- Pointer wrap: winner NUM_INPUTS-1 sets the pointer to 0.
- Reset mid-operation: a pending token in the slot is discarded; no input is acknowledged in the reset cycle (ins_ready forced 0 while rst).
- NUM_INPUTS not a power of 2: pointer arithmetic wraps at NUM_INPUTS, never at 2**INDEX_WIDTH.

Optional Feature:
- Macro: HANDSHAKE_ARB_RR_EN.
- Defined: round-robin as described; the pointer register exists.
- Undefined:
  - Fixed priority, lowest index wins (scan always starts at 0).
  - No pointer register is instantiated.
  - All other timing is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with all ins_valid=1 -> ins_ready=0, outs_valid=0, outs=0, index=0; first grant after rst drops goes to channel 0.
- All four valid continuously, outs_ready=1, ins[i]=0x100+i (RR_EN defined):
  - outs sequence is 0x100, 0x101, 0x102, 0x103, 0x100..., one per cycle.
  - index cycles 0,1,2,3,0.
- Same stimulus with RR_EN undefined -> outs stays 0x100 and index stays 0 every cycle; channels 1-3 never get ready.
- Backpressure: channel 2 valid with 0xABCD and outs_ready=0 for 5 cycles:
  - outs_valid=1 with outs=0xABCD held stable throughout.
  - ins_ready=0 after the first accept.
  - Raise outs_ready: drain plus refill in the same cycle if channel 2 presents 0xBEEF.
- Wrap: pointer at 3, channels 0 and 3 valid -> channel 3 wins and the pointer becomes 0; next cycle channel 0 wins.
- Reset mid-operation: slot full (outs_valid=1, outs=0x55), assert rst for one cycle -> outs_valid=0 and pointer=0 the next cycle; no ins_ready pulse during rst.

Source files
------------

// File: rtl/handshake_arbiter_rr_if.sv
// handshake_arbiter_rr_if: request bundle plus single output channel.
// master drives requests and downstream ready; slave is the arbiter.
interface handshake_arbiter_rr_if #(
   parameter int NUM_INPUTS  = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int INDEX_WIDTH = 2
);
   logic [NUM_INPUTS*DATA_WIDTH-1:0] ins;
   logic [NUM_INPUTS-1:0]            ins_valid;
   logic [NUM_INPUTS-1:0]            ins_ready;
   logic [DATA_WIDTH-1:0]            outs;
   logic [INDEX_WIDTH-1:0]           index;
   logic                             outs_valid;
   logic                             outs_ready;

   modport master (
      output ins, ins_valid, outs_ready,
      input  ins_ready, outs, index, outs_valid
   );

   modport slave (
      input  ins, ins_valid, outs_ready,
      output ins_ready, outs, index, outs_valid
   );
endinterface

// File: rtl/handshake_arbiter_rr.sv
// handshake_arbiter_rr: registered N-to-1 arbitrated merge, one output slot.
// Define HANDSHAKE_ARB_RR_EN for round-robin; otherwise fixed priority.
module handshake_arbiter_rr #(
   parameter int NUM_INPUTS  = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int INDEX_WIDTH = 2
) (
   input logic                   clk,
   input logic                   rst,
   handshake_arbiter_rr_if.slave bus
);
   logic [DATA_WIDTH-1:0]  outs_q, outs_d;
   logic [INDEX_WIDTH-1:0] index_q, index_d;
   logic                   valid_q, valid_d;
   logic [NUM_INPUTS-1:0]  grant;
   logic [INDEX_WIDTH-1:0] win;
   logic [INDEX_WIDTH-1:0] start;
   logic                   any_req;
   logic                   can_load;
   logic                   xfer;

`ifdef HANDSHAKE_ARB_RR_EN
   logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;

   assign start = ptr_q;

   // Wrap at NUM_INPUTS, not at 2**INDEX_WIDTH.
   always_comb begin
      ptr_d = ptr_q;
      if (xfer) begin
         if (int'(win) == NUM_INPUTS - 1)
            ptr_d = '0;
         else
            ptr_d = win + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         ptr_q <= '0;
      else
         ptr_q <= ptr_d;
   end
`else
   assign start = '0;
`endif

   always_comb begin
      int c;
      c       = 0;
      grant   = '0;
      win     = '0;
      any_req = 1'b0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         c = int'(start) + k;
         if (c >= NUM_INPUTS)
            c = c - NUM_INPUTS;
         if (!any_req && bus.ins_valid[c]) begin
            any_req  = 1'b1;
            grant[c] = 1'b1;
            win      = INDEX_WIDTH'(c);
         end
      end
   end

   assign can_load = !valid_q || bus.outs_ready;
   assign xfer     = any_req && can_load && !rst;

   assign bus.ins_ready = rst ? '0
                        : (grant & {NUM_INPUTS{can_load}});

   always_comb begin
      outs_d  = outs_q;
      index_d = index_q;
      valid_d = valid_q;
      if (xfer) begin
         outs_d  = bus.ins[int'(win)*DATA_WIDTH +: DATA_WIDTH];
         index_d = win;
         valid_d = 1'b1;
      end else if (bus.outs_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         outs_q  <= '0;
         index_q <= '0;
         valid_q <= 1'b0;
      end else begin
         outs_q  <= outs_d;
         index_q <= index_d;
         valid_q <= valid_d;
      end
   end

   assign bus.outs       = outs_q;
   assign bus.index      = index_q;
   assign bus.outs_valid = valid_q;
endmodule
